// File: rtl/pcu_nway.sv
// pcu_nway: N-way fetch PC unit with prioritised, buffered redirects.
// Optional PCU_PERF_EN adds saturating stall / applied-redirect counters.
module pcu_nway #(
  parameter int              ADDR_W    = 32,
  parameter int              WAYS      = 2,
  parameter int              NUM_REDIR = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ready_i,
  input  logic [NUM_REDIR-1:0]        redir_valid_i,
  input  logic [NUM_REDIR*ADDR_W-1:0] redir_addr_i,
  output logic                        valid_o,
  output logic [ADDR_W-1:0]           pc_o,
  output logic [WAYS-1:0]             lane_mask_o,
  output logic                        redir_pend_o
`ifdef PCU_PERF_EN
  ,
  output logic [31:0]                 stall_cnt_o,
  output logic [31:0]                 redir_cnt_o
`endif
);

  localparam int BUNDLE_BYTES = 4 * WAYS;
  localparam logic [ADDR_W-1:0] OFS_MASK =
    ADDR_W'(BUNDLE_BYTES - 1);
  localparam logic [ADDR_W-1:0] STEP =
    ADDR_W'(BUNDLE_BYTES);

  typedef enum logic {
    FETCH = 1'b0,
    STALL = 1'b1
  } state_t;

  function automatic logic [WAYS-1:0] first_mask(
    input logic [ADDR_W-1:0] a
  );
    logic [ADDR_W-1:0] lane;
    logic [WAYS-1:0]   m;
    lane = (a >> 2) & ADDR_W'(WAYS - 1);
    for (int i = 0; i < WAYS; i++) begin
      m[i] = (ADDR_W'(i) >= lane);
    end
    return m;
  endfunction

  function automatic logic [ADDR_W-1:0] align(
    input logic [ADDR_W-1:0] a
  );
    return a & ~OFS_MASK;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [WAYS-1:0]   mask_q, mask_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              arb_valid;
  logic [ADDR_W-1:0] arb_addr;
  logic              applied;

  // Fixed priority: lowest asserted channel wins, others dropped.
  always_comb begin
    arb_valid = 1'b0;
    arb_addr  = '0;
    for (int k = NUM_REDIR - 1; k >= 0; k--) begin
      if (redir_valid_i[k]) begin
        arb_valid = 1'b1;
        arb_addr  = redir_addr_i[k*ADDR_W +: ADDR_W];
      end
    end
  end

  // Next PC / mask / pending / state selection.
  always_comb begin
    state_d     = FETCH;
    pc_d        = pc_q;
    mask_d      = mask_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    applied     = 1'b0;
    unique case (1'b1)
      !ready_i: begin
        state_d = STALL;
        if (arb_valid) begin
          pend_d      = 1'b1;
          pend_addr_d = arb_addr;
        end
      end
      ready_i && arb_valid: begin
        pc_d    = align(arb_addr);
        mask_d  = first_mask(arb_addr);
        pend_d  = 1'b0;
        applied = 1'b1;
      end
      ready_i && !arb_valid && pend_q: begin
        pc_d    = align(pend_addr_q);
        mask_d  = first_mask(pend_addr_q);
        pend_d  = 1'b0;
        applied = 1'b1;
      end
      default: begin
        pc_d   = pc_q + STEP;
        mask_d = '1;
      end
    endcase
  end

  // State, PC and pending-buffer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FETCH;
      pc_q        <= align(RESET_PC);
      mask_q      <= first_mask(RESET_PC);
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mask_q      <= mask_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign valid_o      = (state_q == FETCH);
  assign pc_o         = pc_q;
  assign lane_mask_o  = mask_q;
  assign redir_pend_o = pend_q;

`ifdef PCU_PERF_EN
  // Saturating stall and applied-redirect counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_o <= '0;
      redir_cnt_o <= '0;
    end else begin
      if (!ready_i && stall_cnt_o != '1) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (applied && redir_cnt_o != '1) begin
        redir_cnt_o <= redir_cnt_o + 32'd1;
      end
    end
  end
`else
  logic unused_applied;
  assign unused_applied = applied;
`endif

endmodule

// File: tb/tb_pcu_nway.sv
// tb_pcu_nway: directed and randomized checks of pcu_nway
// against a behavioural reference of the redirect/fetch rules.
module tb_pcu_nway;
  localparam int AW = 32;
  localparam int WAYS = 4;
  localparam int NR = 2;
  localparam int BB = 4 * WAYS;
  localparam logic [31:0] RPC = 32'h4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rdy = 1'b1;
  logic [NR-1:0] rv = '0;
  logic [NR*AW-1:0] ra = '0;
  logic valid_o;
  logic [AW-1:0] pc_o;
  logic [WAYS-1:0] lane_mask_o;
  logic redir_pend_o;
`ifdef PCU_PERF_EN
  logic [31:0] stall_cnt_o, redir_cnt_o;
`endif

  int n_tests = 0;
  int n_fail = 0;

  logic [31:0] m_pc, m_pa;
  logic [WAYS-1:0] m_mask;
  logic m_valid, m_pend;
  longint m_stall, m_redir;

  pcu_nway #(
    .ADDR_W(AW), .WAYS(WAYS),
    .NUM_REDIR(NR), .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ready_i(rdy),
    .redir_valid_i(rv),
    .redir_addr_i(ra),
    .valid_o(valid_o),
    .pc_o(pc_o),
    .lane_mask_o(lane_mask_o),
    .redir_pend_o(redir_pend_o)
`ifdef PCU_PERF_EN
    ,
    .stall_cnt_o(stall_cnt_o),
    .redir_cnt_o(redir_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // lanes from the word offset inside the bundle upward are live
  function automatic logic [WAYS-1:0] fm(input logic [31:0] a);
    int lane;
    int full;
    lane = int'((a / 4) % WAYS);
    full = (1 << WAYS) - 1;
    return WAYS'(full - ((1 << lane) - 1));
  endfunction

  task automatic model_reset();
    m_pc = RPC - (RPC % BB);
    m_mask = fm(RPC);
    m_valid = 1'b1;
    m_pend = 1'b0;
    m_pa = '0;
    m_stall = 0;
    m_redir = 0;
  endtask

  task automatic model_tick();
    int win;
    logic [31:0] tgt;
    win = -1;
    for (int k = NR - 1; k >= 0; k--)
      if (rv[k]) win = k;
    if (!rdy) begin
      m_valid = 1'b0;
      if (m_stall < 64'hFFFF_FFFF) m_stall++;
      if (win >= 0) begin
        m_pend = 1'b1;
        m_pa = ra[win*AW +: AW];
      end
    end else if (win >= 0 || m_pend) begin
      tgt = (win >= 0) ? ra[win*AW +: AW] : m_pa;
      m_pc = tgt - (tgt % BB);
      m_mask = fm(tgt);
      m_valid = 1'b1;
      m_pend = 1'b0;
      if (m_redir < 64'hFFFF_FFFF) m_redir++;
    end else begin
      m_pc = m_pc + BB;
      m_mask = '1;
      m_valid = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #2;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    rdy = 1'b1;
    rv = 2'b11;
    ra = {32'h300, 32'h200};
    do_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if (pc_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pc got %h want %h", pc_o, 32'h0);
    end
    n_tests++;
    if (lane_mask_o !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_mask got %b want %b",
               lane_mask_o, 4'b1110);
    end
    n_tests++;
    if (valid_o !== 1'b1 || redir_pend_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got v=%b p=%b want v=1 p=0",
               valid_o, redir_pend_o);
    end
    rv = '0;
    release_reset();
  endtask

  task automatic test_sequential();
    rdy = 1'b1;
    rv = '0;
    step();
    n_tests++;
    if (pc_o !== 32'h10 || lane_mask_o !== 4'b1111) begin
      n_fail++;
      $display("FAIL seq1 got %h/%b want %h/%b",
               pc_o, lane_mask_o, 32'h10, 4'b1111);
    end
    step();
    n_tests++;
    if (pc_o !== 32'h20 || valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL seq2 got %h v=%b want %h v=1",
               pc_o, valid_o, 32'h20);
    end
  endtask

  task automatic test_redirect();
    rdy = 1'b1;
    rv = 2'b01;
    ra = {32'h0, 32'h1008};
    step();
    rv = '0;
    n_tests++;
    if (pc_o !== 32'h1000 || lane_mask_o !== 4'b1100) begin
      n_fail++;
      $display("FAIL redir got %h/%b want %h/%b",
               pc_o, lane_mask_o, 32'h1000, 4'b1100);
    end
    step();
    n_tests++;
    if (pc_o !== 32'h1010 || lane_mask_o !== 4'b1111) begin
      n_fail++;
      $display("FAIL redir_next got %h/%b want %h/%b",
               pc_o, lane_mask_o, 32'h1010, 4'b1111);
    end
  endtask

  task automatic test_arbitration();
    rdy = 1'b1;
    rv = 2'b11;
    ra = {32'h300, 32'h200};
    step();
    rv = '0;
    n_tests++;
    if (pc_o !== 32'h200 || redir_pend_o !== 1'b0) begin
      n_fail++;
      $display("FAIL arb got %h p=%b want %h p=0",
               pc_o, redir_pend_o, 32'h200);
    end
    step();
    n_tests++;
    if (pc_o !== 32'h210) begin
      n_fail++;
      $display("FAIL arb_drop got %h want %h", pc_o, 32'h210);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    held = pc_o;
    rdy = 1'b0;
    rv = 2'b01;
    ra = {32'h0, 32'h40};
    step();
    ra = {32'h0, 32'h80};
    step();
    rv = '0;
    step();
    n_tests++;
    if (valid_o !== 1'b0 || pc_o !== held) begin
      n_fail++;
      $display("FAIL stall_hold got %h v=%b want %h v=0",
               pc_o, valid_o, held);
    end
    n_tests++;
    if (redir_pend_o !== 1'b1 || lane_mask_o !== 4'b1111) begin
      n_fail++;
      $display("FAIL stall_pend got p=%b m=%b want p=1 m=1111",
               redir_pend_o, lane_mask_o);
    end
    rdy = 1'b1;
    step();
    n_tests++;
    if (pc_o !== 32'h80 || valid_o !== 1'b1 ||
        redir_pend_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_apply got %h v=%b p=%b want %h v=1 p=0",
               pc_o, valid_o, redir_pend_o, 32'h80);
    end
  endtask

  task automatic test_wrap();
    rdy = 1'b1;
    rv = 2'b10;
    ra = {32'hFFFF_FFF8, 32'h0};
    step();
    rv = '0;
    n_tests++;
    if (pc_o !== 32'hFFFF_FFF0 || lane_mask_o !== 4'b1100) begin
      n_fail++;
      $display("FAIL wrap_top got %h/%b want %h/%b",
               pc_o, lane_mask_o, 32'hFFFF_FFF0, 4'b1100);
    end
    step();
    n_tests++;
    if (pc_o !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap got %h want %h", pc_o, 32'h0);
    end
  endtask

`ifdef PCU_PERF_EN
  task automatic test_perf();
    rdy = 1'b0;
    rv = 2'b01;
    ra = {32'h0, 32'h40};
    step();
    rv = '0;
    do_reset();
    n_tests++;
    if (pc_o !== 32'h0 || redir_pend_o !== 1'b0 ||
        stall_cnt_o !== 32'd0 || redir_cnt_o !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_reset got %h p=%b s=%0d r=%0d",
               pc_o, redir_pend_o, stall_cnt_o, redir_cnt_o);
    end
    release_reset();
    repeat (5) step();
    rdy = 1'b1;
    rv = 2'b10;
    ra = {32'h500, 32'h0};
    step();
    rv = 2'b01;
    ra = {32'h0, 32'h600};
    step();
    rv = '0;
    n_tests++;
    if (stall_cnt_o !== 32'd5 || redir_cnt_o !== 32'd2) begin
      n_fail++;
      $display("FAIL perf_cnt got s=%0d r=%0d want s=5 r=2",
               stall_cnt_o, redir_cnt_o);
    end
    n_tests++;
    if (pc_o !== 32'h600) begin
      n_fail++;
      $display("FAIL perf_pc got %h want %h", pc_o, 32'h600);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 2) == 0) ? NR'($urandom) : '0;
      ra = {$urandom, $urandom};
      step();
      n_tests++;
      if ({pc_o, lane_mask_o, valid_o, redir_pend_o} !==
          {m_pc, m_mask, m_valid, m_pend}) begin
        n_fail++;
        $display("FAIL rand[%0d] got %h/%b/%b/%b want %h/%b/%b/%b",
                 i, pc_o, lane_mask_o, valid_o, redir_pend_o,
                 m_pc, m_mask, m_valid, m_pend);
      end
`ifdef PCU_PERF_EN
      n_tests++;
      if ({stall_cnt_o, redir_cnt_o} !==
          {m_stall[31:0], m_redir[31:0]}) begin
        n_fail++;
        $display("FAIL rand_cnt[%0d] got %0d/%0d want %0d/%0d",
                 i, stall_cnt_o, redir_cnt_o, m_stall, m_redir);
      end
`endif
    end
    rv = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_redirect();
    test_arbitration();
    test_stall();
    test_wrap();
`ifdef PCU_PERF_EN
    test_perf();
`endif
    do_reset();
    release_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pcu_nway.md
Name: pcu_nway

Overview:
- N-way program counter unit for the superscalar front end.
- Each cycle it issues one fetch-bundle base address and a per-lane valid mask to the instruction fetch stage.
- Accepts redirects from several prioritised sources (branch, exception, ...) and buffers a redirect that arrives while fetch is stalled.
- Generalises the fixed 2-way, single-redirect PC unit to any power-of-two fetch width, any redirect channel count and unaligned redirect targets.

Parameters:
- ADDR_W, 32, address width in bits.
- WAYS, 2, instructions per fetch bundle; power of two, 1..8. BUNDLE_BYTES = 4*WAYS; OFS_W = log2(BUNDLE_BYTES).
- NUM_REDIR, 2, number of redirect channels; index 0 has highest priority.
- RESET_PC, 32'h4, first fetch address after reset.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- ready_i  in  1  fetch stage can accept a bundle this cycle
- redir_valid_i  in  NUM_REDIR  per-channel redirect request, single-cycle pulse
- redir_addr_i  in  NUM_REDIR*ADDR_W  per-channel target; channel k occupies bits [k*ADDR_W +: ADDR_W]
- valid_o  out  1  pc_o / lane_mask_o valid
- pc_o  out  ADDR_W  bundle base address, low OFS_W bits always 0
- lane_mask_o  out  WAYS  bit i set = instruction at pc_o+4*i is live
- redir_pend_o  out  1  a redirect is buffered, not yet applied

Behaviour:
- Reset (async assert, sync release): pc_o = RESET_PC with low OFS_W bits cleared; lane_mask_o = first_mask(RESET_PC); valid_o = 1; pending register cleared; state = FETCH.
- first_mask(a): lane i set iff i >= a[OFS_W-1:2]; a[1:0] ignored (forced 0).
- Arbitration: lowest asserted index of redir_valid_i wins. Losers in the same cycle are dropped, not queued.
- Pending buffer:
  - One entry (addr + flag).
  - Written whenever a redirect is arbitrated and not applied that cycle.
  - A newer redirect always overwrites an older pending one.
- Next-state rules, per rising edge, in priority order:
  1. ready_i = 0: pc_o and lane_mask_o hold; valid_o <= 0; state STALL. Any incoming redirect goes to pending.
  2. ready_i = 1 with incoming redirect: pc_o <= align(target); lane_mask_o <= first_mask(target); valid_o <= 1; pending cleared, because the incoming redirect is newer.
  3. ready_i = 1 with pending set: apply the pending target as in rule 2; clear pending.
  4. Otherwise: pc_o <= pc_o + BUNDLE_BYTES, modulo 2^ADDR_W with silent wrap; lane_mask_o <= all ones; valid_o <= 1.
- States:
  - FETCH: valid_o = 1.
  - STALL: valid_o = 0. Goes to FETCH on the first edge with ready_i = 1.
  - Redirect latency: one cycle from a redirect pulse to pc_o = target when ready_i = 1; otherwise applied on the first ready edge.
- Redirect during reset assertion is ignored.
- redir_pend_o is a direct copy of the pending flag.
- lane_mask_o is only meaningful when valid_o = 1, but must still hold its last value while stalled.

Optional Feature:
- PCU_PERF_EN defined adds outputs stall_cnt_o[31:0] and redir_cnt_o[31:0]. Both reset to 0 and saturate at 32'hFFFF_FFFF.
  - stall_cnt_o increments each cycle ready_i = 0.
  - redir_cnt_o increments on each applied redirect (rules 2 and 3), not on overwritten pending entries.
- Undefined: ports absent, no counter logic.

Test Plan:
- WAYS=2, RESET_PC=4; release reset with ready_i=1 -> pc_o=0x0, mask=2'b10, valid_o=1; next cycles pc_o=0x8, 0x10, mask=2'b11.
- WAYS=4; redirect ch0 to 0x1008 with ready_i=1 -> next cycle pc_o=0x1000, mask=4'b1100; following cycle pc_o=0x1010, mask=4'b1111.
- Same-cycle ch0=0x200 and ch1=0x300 -> pc_o=0x200; ch1 dropped; redir_pend_o=0.
- Hold ready_i=0 for 3 cycles, redirect 0x40 then 0x80 during the stall -> valid_o=0 and pc held; redir_pend_o=1; on ready_i=1 pc_o=0x80, valid_o=1, redir_pend_o=0.
- ADDR_W=32, WAYS=2; redirect to 0xFFFF_FFF8 then run -> pc_o sequence 0xFFFF_FFF8, 0x0000_0000 (wrap).
- PCU_PERF_EN on; assert reset_n=0 mid-stall with pending set -> pc_o=RESET_PC aligned, pending cleared, counters 0; after 5 stall cycles and 2 redirects -> stall_cnt_o=5, redir_cnt_o=2.
